cfu_wb_burst_fetch: RTL and testbench

Wishbone burst-read engine feeding the CFU compute datapath. It takes a start word address and length from the CFU sequencer. It issues an incrementing-burst read on the CFU RAM bus and streams the returned words into a small FIFO. A downstream adder/MAC drains the FIFO through a valid/ready interface. This replaces the per-word single read used by the fetch/add pipeline with multi-word fetches that honour backpressure.

---
 rtl/cfu_wb_burst_fetch.sv | 129 ++++++++++++
 tb/tb_cfu_wb_burst_fetch.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_wb_burst_fetch.sv
// Wishbone incrementing-burst read engine for the CFU datapath.
// Streams returned words into a small FIFO drained over valid/ready.
module cfu_wb_burst_fetch #(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [29:0]      req_addr,
   input  logic [LEN_W-1:0] req_len,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             out_last,
   output logic             out_err,
   output logic [29:0]      cfu_ram_adr,
   output logic [31:0]      cfu_ram_dat_mosi,
   output logic [3:0]       cfu_ram_sel,
   output logic             cfu_ram_cyc,
   output logic             cfu_ram_stb,
   output logic             cfu_ram_we,
   output logic [2:0]       cfu_ram_cti,
   output logic [1:0]       cfu_ram_bte,
   input  logic [31:0]      cfu_ram_dat_miso,
   input  logic             cfu_ram_ack,
   input  logic             cfu_ram_err
);

   localparam int CW = $clog2(FIFO_DEPTH);
   localparam logic [CW:0] FULL = (CW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

   state_t           state;
   state_t           state_nx;
   logic [29:0]      adr_q;
   logic [LEN_W-1:0] remaining;
   logic [31:0]      mem_d [FIFO_DEPTH];
   logic             mem_l [FIFO_DEPTH];
   logic             mem_e [FIFO_DEPTH];
   logic [CW-1:0]    wr_ptr;
   logic [CW-1:0]    rd_ptr;
   logic [CW:0]      count;
   logic             last_beat;
   logic             beat;
   logic             pop;

   assign last_beat = remaining == LEN_W'(1);

   // stb is gated on the registered count so an accepted beat always fits
   assign cfu_ram_cyc = state == BURST;
   assign cfu_ram_stb = (state == BURST) && (count < FULL);
   assign cfu_ram_cti = (state != BURST) ? 3'b000 :
                        last_beat        ? 3'b111 : 3'b010;
   assign cfu_ram_adr      = adr_q;
   assign cfu_ram_dat_mosi = '0;
   assign cfu_ram_sel      = 4'b1111;
   assign cfu_ram_we       = 1'b0;
   assign cfu_ram_bte      = 2'b00;

   assign beat      = cfu_ram_stb && (cfu_ram_ack || cfu_ram_err);
   assign out_valid = count != '0;
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem_d[rd_ptr] : '0;
   assign out_last  = out_valid && mem_l[rd_ptr];
   assign out_err   = out_valid && mem_e[rd_ptr];

   assign req_ready = state == IDLE;
   assign busy      = state != IDLE;

   always_ff @(negedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:
            if (req_valid)
               state_nx = (req_len != '0) ? BURST : DRAIN;
         BURST:
            if (beat && (cfu_ram_err || last_beat))
               state_nx = DRAIN;
         DRAIN:
            if (count == '0)
               state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         adr_q     <= '0;
         remaining <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else begin
         if (state == IDLE && req_valid) begin
            adr_q     <= req_addr;
            remaining <= req_len;
         end else if (beat && !cfu_ram_err) begin
            adr_q     <= adr_q + 30'd1;
            remaining <= remaining - LEN_W'(1);
         end
         if (beat) wr_ptr <= wr_ptr + CW'(1);
         if (pop)  rd_ptr <= rd_ptr + CW'(1);
         unique case ({beat, pop})
            2'b10:   count <= count + (CW+1)'(1);
            2'b01:   count <= count - (CW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // error beats carry zero data and terminate the stream
   always_ff @(negedge clk) begin
      if (beat) begin
         mem_d[wr_ptr] <= cfu_ram_err ? 32'd0 : cfu_ram_dat_miso;
         mem_l[wr_ptr] <= cfu_ram_err || last_beat;
         mem_e[wr_ptr] <= cfu_ram_err;
      end
   end

endmodule

// File: tb/tb_cfu_wb_burst_fetch.sv
// Directed bench for cfu_wb_burst_fetch: Wishbone slave model,
// consumer capture queue and hand-computed expectations.
module tb_cfu_wb_burst_fetch;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [29:0] req_addr;
   logic [7:0]  req_len;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        out_err;
   logic [29:0] cfu_ram_adr;
   logic [31:0] cfu_ram_dat_mosi;
   logic [3:0]  cfu_ram_sel;
   logic        cfu_ram_cyc;
   logic        cfu_ram_stb;
   logic        cfu_ram_we;
   logic [2:0]  cfu_ram_cti;
   logic [1:0]  cfu_ram_bte;
   logic [31:0] cfu_ram_dat_miso;
   logic        cfu_ram_ack;
   logic        cfu_ram_err;

   cfu_wb_burst_fetch #(.FIFO_DEPTH(4), .LEN_W(8)) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr(req_addr),
      .req_len(req_len),
      .busy(busy),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_last(out_last),
      .out_err(out_err),
      .cfu_ram_adr(cfu_ram_adr),
      .cfu_ram_dat_mosi(cfu_ram_dat_mosi),
      .cfu_ram_sel(cfu_ram_sel),
      .cfu_ram_cyc(cfu_ram_cyc),
      .cfu_ram_stb(cfu_ram_stb),
      .cfu_ram_we(cfu_ram_we),
      .cfu_ram_cti(cfu_ram_cti),
      .cfu_ram_bte(cfu_ram_bte),
      .cfu_ram_dat_miso(cfu_ram_dat_miso),
      .cfu_ram_ack(cfu_ram_ack),
      .cfu_ram_err(cfu_ram_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   int          ws, err_beat, beat, ws_cnt, rr_low, unstable, n;
   bit          rdy_en, saw_cyc, saw_ov, saw_bad, bad_en;
   logic [29:0] bad_adr, hold_adr;
   logic [2:0]  hold_cti;
   logic [31:0] dbase;
   logic [29:0] adr_log[$];
   logic [2:0]  cti_log[$];
   logic [31:0] got_d[$];
   logic        got_l[$];
   logic        got_e[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clr();
      adr_log.delete(); cti_log.delete();
      got_d.delete(); got_l.delete(); got_e.delete();
      beat = 0; ws_cnt = 0; rr_low = 0; unstable = 0;
      saw_cyc = 0; saw_ov = 0; saw_bad = 0; bad_en = 0;
      err_beat = -1; ws = 0;
   endtask

   // One cycle: observe at posedge, then drive for the next negedge
   task automatic step();
      @(posedge clk);
      req_valid = 1'b0;
      if (!req_ready) rr_low++;
      if (out_valid) saw_ov = 1;
      if (cfu_ram_cyc) begin
         saw_cyc = 1;
         if (bad_en && cfu_ram_adr == bad_adr) saw_bad = 1;
      end
      out_ready = rdy_en;
      if (out_valid && out_ready) begin
         got_d.push_back(out_data);
         got_l.push_back(out_last);
         got_e.push_back(out_err);
      end
      cfu_ram_ack = 1'b0;
      cfu_ram_err = 1'b0;
      if (cfu_ram_cyc && cfu_ram_stb) begin
         if (ws_cnt == 0) begin
            hold_adr = cfu_ram_adr;
            hold_cti = cfu_ram_cti;
         end else if (cfu_ram_adr != hold_adr || cfu_ram_cti != hold_cti) begin
            unstable++;
         end
         if (ws_cnt == ws) begin
            ws_cnt = 0;
            if (beat == err_beat) cfu_ram_err = 1'b1;
            else                  cfu_ram_ack = 1'b1;
            adr_log.push_back(cfu_ram_adr);
            cti_log.push_back(cfu_ram_cti);
            cfu_ram_dat_miso = dbase + 32'(beat);
            beat++;
         end else begin
            ws_cnt++;
         end
      end
   endtask

   task automatic run(input logic [29:0] a, input logic [7:0] l,
                      input int maxc);
      req_addr  = a;
      req_len   = l;
      req_valid = 1'b1;
      step();
      n = 0;
      while (busy && n < maxc) begin
         step();
         n++;
      end
      chk("timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 1'b0; req_addr = '0; req_len = '0;
      out_ready = 1'b0; rdy_en = 1'b0; dbase = '0;
      cfu_ram_dat_miso = '0; cfu_ram_ack = 1'b0; cfu_ram_err = 1'b0;
      bad_adr = '0; hold_adr = '0; hold_cti = '0;
      clr();
      repeat (2) @(posedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_flags", {30'd0, out_last, out_err}, 32'd0);
      chk("rst_cyc_stb", {30'd0, cfu_ram_cyc, cfu_ram_stb}, 32'd0);
      chk("rst_cti", 32'(cfu_ram_cti), 32'd0);
      chk("rst_adr", 32'(cfu_ram_adr), 32'd0);
      chk("tie_sel_we", {27'd0, cfu_ram_sel, cfu_ram_we}, 32'h1E);
      chk("tie_mosi_bte", cfu_ram_dat_mosi | 32'(cfu_ram_bte), 32'd0);
      reset = 1'b0;

      // basic 4-word burst
      clr(); rdy_en = 1; dbase = 32'hA0;
      run(30'h100, 8'd4, 40);
      chk("b4_nbeats", adr_log.size(), 4);
      chk("b4_nout", got_d.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < adr_log.size()) begin
            chk("b4_adr", 32'(adr_log[i]), 32'h100 + 32'(i));
            chk("b4_cti", 32'(cti_log[i]), (i == 3) ? 32'd7 : 32'd2);
         end
         if (i < got_d.size()) begin
            chk("b4_data", got_d[i], 32'hA0 + 32'(i));
            chk("b4_last", 32'(got_l[i]), (i == 3) ? 32'd1 : 32'd0);
            chk("b4_err", 32'(got_e[i]), 32'd0);
         end
      end
      chk("b4_req_ready", 32'(req_ready), 32'd1);

      // backpressure: 8 words through a 4-deep FIFO
      clr(); rdy_en = 0; dbase = 32'h1000;
      req_addr = 30'h500; req_len = 8'd8; req_valid = 1'b1;
      repeat (12) step();
      chk("bp_acks", beat, 4);
      chk("bp_stb", 32'(cfu_ram_stb), 32'd0);
      chk("bp_cyc", 32'(cfu_ram_cyc), 32'd1);
      chk("bp_adr_hold", 32'(cfu_ram_adr), 32'h504);
      rdy_en = 1;
      n = 0;
      while (busy && n < 80) begin
         step();
         n++;
      end
      chk("bp_timeout", 32'(busy), 32'd0);
      chk("bp_nout", got_d.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < got_d.size()) begin
            chk("bp_data", got_d[i], 32'h1000 + 32'(i));
            chk("bp_last", 32'(got_l[i]), (i == 7) ? 32'd1 : 32'd0);
         end
         if (i < adr_log.size())
            chk("bp_adr", 32'(adr_log[i]), 32'h500 + 32'(i));
      end

      // bus error on the second beat of five
      clr(); rdy_en = 1; dbase = 32'hBEEF0000; err_beat = 1;
      bad_en = 1; bad_adr = 30'h202;
      run(30'h200, 8'd5, 40);
      chk("er_nout", got_d.size(), 2);
      if (got_d.size() == 2) begin
         chk("er_w0", got_d[0], 32'hBEEF0000);
         chk("er_w0_flags", {30'd0, got_l[0], got_e[0]}, 32'd0);
         chk("er_w1", got_d[1], 32'd0);
         chk("er_w1_flags", {30'd0, got_l[1], got_e[1]}, 32'd3);
      end
      chk("er_no_base2", 32'(saw_bad), 32'd0);
      chk("er_cyc", 32'(cfu_ram_cyc), 32'd0);

      // zero-length request
      clr(); rdy_en = 1;
      run(30'h300, 8'd0, 10);
      chk("z_rr_low", rr_low, 1);
      chk("z_cyc", 32'(saw_cyc), 32'd0);
      chk("z_ov", 32'(saw_ov), 32'd0);

      // three wait states per beat
      clr(); rdy_en = 1; dbase = 32'hC0; ws = 3;
      run(30'h40, 8'd2, 40);
      chk("ws_unstable", unstable, 0);
      chk("ws_nout", got_d.size(), 2);
      if (got_d.size() == 2) begin
         chk("ws_d0", got_d[0], 32'hC0);
         chk("ws_d1", got_d[1], 32'hC1);
      end
      chk("ws_cti", (cti_log.size() == 2) ? 32'(cti_log[1]) : 32'hFF, 32'd7);

      // asynchronous reset mid-burst
      clr(); rdy_en = 0; dbase = 32'hD0;
      req_addr = 30'h80; req_len = 8'd6; req_valid = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (beat < 2 && n < 20);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("ar_cyc", 32'(cfu_ram_cyc), 32'd0);
      chk("ar_stb", 32'(cfu_ram_stb), 32'd0);
      chk("ar_ov", 32'(out_valid), 32'd0);
      cfu_ram_ack = 1'b0;
      repeat (2) @(posedge clk);
      reset = 1'b0;

      // single word at the top of the address space
      clr(); rdy_en = 1; dbase = 32'h5A5A0000;
      run(30'h3FFFFFFF, 8'd1, 20);
      chk("wr_nbeats", adr_log.size(), 1);
      if (adr_log.size() == 1) begin
         chk("wr_adr", 32'(adr_log[0]), 32'h3FFFFFFF);
         chk("wr_cti", 32'(cti_log[0]), 32'd7);
      end
      chk("wr_nout", got_d.size(), 1);
      if (got_d.size() == 1) begin
         chk("wr_data", got_d[0], 32'h5A5A0000);
         chk("wr_last", 32'(got_l[0]), 32'd1);
      end
      chk("wr_adr_wrap", 32'(cfu_ram_adr), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
